lcd_refresh_ctrl: RTL and testbench

//  Sequencer between the 32-entry character RAM and the HD44780-style 16x2 LCD.

---
 rtl/lcd_pkg.sv | 43 ++++
 rtl/lcd_write_strobe.sv | 90 +++++++++
 rtl/lcd_refresh_ctrl.sv | 148 ++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the LCD refresh sequencer.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNC    = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_LINE1       = 8'h80;
    localparam logic [7:0] LCD_LINE2       = 8'hC0;

    localparam int LCD_COLS  = 16;
    localparam int LCD_CHARS = 32;

    // Wide enough for the largest wait (1_000_000 power-up cycles)
    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_LINE1,
        ST_LINE2
    } top_state_e;

    typedef enum logic [2:0] {
        WS_IDLE,
        WS_SETUP,
        WS_EN_HI,
        WS_HOLD,
        WS_WAIT
    } strobe_state_e;

    // Init command sequence, indexed 0..3
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNC;
            2'd1:    return LCD_CMD_DISP_ON;
            2'd2:    return LCD_CMD_ENTRY;
            default: return LCD_CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: SETUP (data/rs latched), EN_HI, HOLD, then the post-write wait.
// A new req accepted in the last wait cycle starts the next write with no gap.
module lcd_write_strobe
    import lcd_pkg::*;
#(
    parameter int EN_HIGH_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2_500,
    parameter int CLEAR_WAIT_CYC = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       done
);

    strobe_state_e    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             long_q;
    logic             load;

    // State, counter and latched bus values; data/rs only change on a write start
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WS_IDLE;
            cnt      <= '0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                lcd_data <= data;
                lcd_rs   <= rs;
                long_q   <= long_wait;
            end
        end
    end

    // Next-state and countdown; every countdown exits exactly at zero
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        done    = 1'b0;
        case (state)
            WS_IDLE: begin
                if (req) begin
                    load    = 1'b1;
                    state_n = WS_SETUP;
                end
            end
            WS_SETUP: begin
                state_n = WS_EN_HI;
                cnt_n   = CNT_W'(EN_HIGH_CYC - 1);
            end
            WS_EN_HI: begin
                if (cnt == '0) state_n = WS_HOLD;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            WS_HOLD: begin
                state_n = WS_WAIT;
                cnt_n   = long_q ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
            end
            WS_WAIT: begin
                if (cnt == '0) begin
                    done = 1'b1;
                    if (req) begin
                        load    = 1'b1;
                        state_n = WS_SETUP;
                    end else begin
                        state_n = WS_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = WS_IDLE;
        endcase
    end

    assign lcd_en = (state == WS_EN_HI);

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Top sequencer: power-up delay, LCD init, then frame copies of the 32-char RAM.
// Each write request is raised in the cycle before its SETUP; char_addr advances
// as a character write starts, so it is stable for the whole following write.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 1_000_000,
    parameter int EN_HIGH_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2_500,
    parameter int CLEAR_WAIT_CYC = 100_000,
    parameter int AUTO_REFRESH   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh,
    output logic [5:0] char_addr,
    input  logic [7:0] char_data,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       busy,
    output logic       frame_done
);

    top_state_e       state, state_n;
    logic [CNT_W-1:0] pu_cnt, pu_cnt_n;
    logic [1:0]       init_idx, init_idx_n;
    logic [5:0]       char_addr_n, addr_inc;
    logic             pend, pend_n;
    logic             req, wr_rs, wr_long, wr_done;
    logic [7:0]       wr_data;

    assign addr_inc = (char_addr == 6'(LCD_CHARS - 1)) ? 6'd0 : char_addr + 6'd1;

    // Control registers; reset restarts the whole power-up and init sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_POWERUP;
            pu_cnt    <= CNT_W'(POWERUP_CYC - 1);
            init_idx  <= 2'd0;
            char_addr <= 6'd0;
            pend      <= 1'b0;
        end else begin
            state     <= state_n;
            pu_cnt    <= pu_cnt_n;
            init_idx  <= init_idx_n;
            char_addr <= char_addr_n;
            pend      <= pend_n;
        end
    end

    // Sequencing: pick the next write when the previous one reports done
    always_comb begin
        state_n     = state;
        pu_cnt_n    = pu_cnt;
        init_idx_n  = init_idx;
        char_addr_n = char_addr;
        pend_n      = pend | (refresh & (state != ST_IDLE));
        req         = 1'b0;
        wr_rs       = 1'b0;
        wr_data     = 8'h00;
        wr_long     = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_POWERUP: begin
                if (pu_cnt == '0) begin
                    req        = 1'b1;
                    wr_data    = init_cmd(2'd0);
                    init_idx_n = 2'd0;
                    state_n    = ST_INIT;
                end else begin
                    pu_cnt_n = pu_cnt - CNT_W'(1);
                end
            end
            ST_INIT: begin
                if (wr_done) begin
                    if (init_idx == 2'd3) begin
                        state_n = ST_IDLE;
                    end else begin
                        req        = 1'b1;
                        wr_data    = init_cmd(init_idx + 2'd1);
                        wr_long    = (init_cmd(init_idx + 2'd1) == LCD_CMD_CLEAR);
                        init_idx_n = init_idx + 2'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh || pend || (AUTO_REFRESH != 0)) begin
                    req     = 1'b1;
                    wr_data = LCD_LINE1;
                    pend_n  = 1'b0;
                    state_n = ST_LINE1;
                end
            end
            ST_LINE1: begin
                if (wr_done) begin
                    req = 1'b1;
                    if (char_addr == 6'(LCD_COLS)) begin
                        wr_data = LCD_LINE2;
                        state_n = ST_LINE2;
                    end else begin
                        wr_rs       = 1'b1;
                        wr_data     = char_data;
                        char_addr_n = addr_inc;
                    end
                end
            end
            ST_LINE2: begin
                if (wr_done) begin
                    if (char_addr == 6'd0) begin
                        frame_done = 1'b1;
                        state_n    = ST_IDLE;
                    end else begin
                        req         = 1'b1;
                        wr_rs       = 1'b1;
                        wr_data     = char_data;
                        char_addr_n = addr_inc;
                    end
                end
            end
            default: state_n = ST_POWERUP;
        endcase
    end

    lcd_write_strobe #(
        .EN_HIGH_CYC    (EN_HIGH_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_strobe (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rs        (wr_rs),
        .data      (wr_data),
        .long_wait (wr_long),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .done      (wr_done)
    );

    assign lcd_rw = 1'b0;
    assign lcd_on = 1'b1;
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: scoreboard of expected LCD writes plus timing checks.
module tb_lcd_refresh_ctrl;

    logic       clk = 1'b0;
    logic       reset, reset_b, refresh;
    logic [5:0] char_addr, char_addr_b;
    logic [7:0] char_data, char_data_b;
    logic [7:0] lcd_data, lcd_data_b;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy, frame_done;
    logic       lcd_rs_b, lcd_rw_b, lcd_en_b, lcd_on_b, busy_b, frame_done_b;

    logic [7:0] ram [32];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [8:0] exp_q[$];
    int         rise_t[$];
    int         fdb_t[$];
    int         n_strobe = 0;
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    int         fd_run = 0;
    int         busy_fall = 0;
    int         n_rise_b = 0;
    int         busy_low_b = 0;
    logic       en_prev = 1'b0, busy_prev = 1'b1, fd_prev = 1'b0, en_prev_b = 1'b0;
    logic       skip_len = 1'b0;
    logic       stable = 1'b1;
    logic [8:0] d_rise = '0;
    int         en_len = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign char_data   = ram[char_addr[4:0]];
    assign char_data_b = ram[char_addr_b[4:0]];

    lcd_refresh_ctrl #(
        .POWERUP_CYC(20), .EN_HIGH_CYC(3), .CMD_WAIT_CYC(5), .CLEAR_WAIT_CYC(10), .AUTO_REFRESH(0)
    ) dut (
        .clk(clk), .reset(reset), .refresh(refresh), .char_addr(char_addr), .char_data(char_data),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on),
        .busy(busy), .frame_done(frame_done)
    );

    lcd_refresh_ctrl #(
        .POWERUP_CYC(20), .EN_HIGH_CYC(3), .CMD_WAIT_CYC(5), .CLEAR_WAIT_CYC(10), .AUTO_REFRESH(1)
    ) dut_auto (
        .clk(clk), .reset(reset_b), .refresh(1'b0), .char_addr(char_addr_b), .char_data(char_data_b),
        .lcd_data(lcd_data_b), .lcd_rs(lcd_rs_b), .lcd_rw(lcd_rw_b), .lcd_en(lcd_en_b), .lcd_on(lcd_on_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_frame();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, ram[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, ram[i]});
    endtask

    task automatic wait_strobes(input int target, input int limit);
        for (int i = 0; i < limit && n_strobe < target; i++) tick();
        chk_eq("tmo_strobes", 32'(n_strobe >= target), 1);
    endtask

    task automatic wait_fd(input int target, input int limit);
        for (int i = 0; i < limit && fd_cnt < target; i++) tick();
        chk_eq("tmo_frame_done", 32'(fd_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy; i++) tick();
        chk_eq("tmo_idle", 32'(busy), 0);
    endtask

    // Write monitor: scoreboard pop on each enable rise, strobe width and stability
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            n_strobe++;
            rise_t.push_back(cyc);
            chk_eq("rw", 32'(lcd_rw), 0);
            if (exp_q.size() == 0) chk_eq("sb_underflow", 32'(exp_q.size()), 1);
            else chk_eq("strobe", 32'({lcd_rs, lcd_data}), 32'(exp_q.pop_front()));
            d_rise = {lcd_rs, lcd_data};
            en_len = 1;
            stable = 1'b1;
        end else if (lcd_en) begin
            en_len++;
            if ({lcd_rs, lcd_data} != d_rise) stable = 1'b0;
        end else if (en_prev) begin
            if (!skip_len) chk_eq("en_len", 32'(en_len), 3);
            chk_eq("en_stable", 32'(stable), 1);
            skip_len = 1'b0;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            fd_run = fd_prev ? fd_run + 1 : 1;
        end else if (fd_prev) begin
            chk_eq("fd_width", 32'(fd_run), 1);
        end
        if (!busy && busy_prev) busy_fall = cyc;
        en_prev   = lcd_en;
        fd_prev   = frame_done;
        busy_prev = busy;
    end

    // Auto-refresh instance monitor
    always @(negedge clk) begin
        if (lcd_en_b && !en_prev_b) n_rise_b++;
        if (frame_done_b) fdb_t.push_back(cyc);
        if (!busy_b) busy_low_b++;
        en_prev_b = lcd_en_b;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        string s1, s2;
        int rel, rq, base_fd, nb, bl, rb;
        s1 = "HELLO WORLD.....";
        s2 = "0123456789ABCDEF";
        for (int i = 0; i < 16; i++) begin
            ram[i]      = s1[i];
            ram[i + 16] = s2[i];
        end
        reset = 1'b1;
        reset_b = 1'b1;
        refresh = 1'b0;
        repeat (3) tick();

        // Reset values
        chk_eq("rst_char_addr", 32'(char_addr), 0);
        chk_eq("rst_lcd_data", 32'(lcd_data), 0);
        chk_eq("rst_lcd_rs", 32'(lcd_rs), 0);
        chk_eq("rst_lcd_rw", 32'(lcd_rw), 0);
        chk_eq("rst_lcd_en", 32'(lcd_en), 0);
        chk_eq("rst_lcd_on", 32'(lcd_on), 1);
        chk_eq("rst_busy", 32'(busy), 1);
        chk_eq("rst_frame_done", 32'(frame_done), 0);

        // 1: power-up delay and init sequence
        push_init();
        reset = 1'b0;
        reset_b = 1'b0;
        rel = cyc;
        rise_t.delete();
        wait_strobes(4, 200);
        wait_idle(100);
        if (rise_t.size() >= 4) begin
            chk_eq("powerup_delay", 32'(rise_t[0] - rel), 21);
            chk_eq("cmd_gap", 32'(rise_t[1] - rise_t[0]), 10);
            chk_eq("clear_wait", 32'(busy_fall - rise_t[3]), 14);
        end
        chk_eq("init_sb_empty", 32'(exp_q.size()), 0);

        // 2: one refresh pulse copies a full frame
        base_fd = fd_cnt;
        nb = n_strobe;
        push_frame();
        rise_t.delete();
        rq = cyc;
        pulse_refresh();
        wait_fd(base_fd + 1, 600);
        repeat (20) tick();
        if (rise_t.size() >= 1) begin
            chk_eq("refresh_latency", 32'(rise_t[0] - rq), 2);
            chk_eq("frame_length", 32'(fd_cyc - rise_t[0]), 338);
        end
        chk_eq("frame_strobes", 32'(n_strobe - nb), 34);
        chk_eq("frame_done_count", 32'(fd_cnt - base_fd), 1);
        chk_eq("addr_end", 32'(char_addr), 0);
        chk_eq("idle_busy", 32'(busy), 0);
        chk_eq("frame_sb_empty", 32'(exp_q.size()), 0);

        // 3: three requests during a frame give exactly one more frame
        for (int i = 0; i < 32; i++) ram[i] = ram[31 - i] ^ 8'h20;
        base_fd = fd_cnt;
        push_frame();
        push_frame();
        pulse_refresh();
        repeat (40) tick();
        pulse_refresh();
        repeat (30) tick();
        pulse_refresh();
        repeat (30) tick();
        pulse_refresh();
        wait_fd(base_fd + 2, 1200);
        repeat (40) tick();
        chk_eq("pend_frames", 32'(fd_cnt - base_fd), 2);
        chk_eq("pend_idle", 32'(busy), 0);
        chk_eq("pend_sb_empty", 32'(exp_q.size()), 0);

        // 4: reset mid-strobe on char 7, then full replay with a request held from power-up
        base_fd = fd_cnt;
        nb = n_strobe;
        push_frame();
        pulse_refresh();
        wait_strobes(nb + 9, 300);
        chk_eq("abort_en_high", 32'(lcd_en), 1);
        reset = 1'b1;
        skip_len = 1'b1;
        tick();
        chk_eq("abort_en_low", 32'(lcd_en), 0);
        chk_eq("abort_busy", 32'(busy), 1);
        chk_eq("abort_addr", 32'(char_addr), 0);
        chk_eq("abort_data", 32'(lcd_data), 0);
        exp_q.delete();
        push_init();
        push_frame();
        tick();
        reset = 1'b0;
        rel = cyc;
        rise_t.delete();
        repeat (5) tick();
        pulse_refresh();
        wait_fd(base_fd + 1, 800);
        repeat (20) tick();
        if (rise_t.size() >= 1) chk_eq("replay_powerup", 32'(rise_t[0] - rel), 21);
        chk_eq("replay_frames", 32'(fd_cnt - base_fd), 1);
        chk_eq("replay_sb_empty", 32'(exp_q.size()), 0);
        chk_eq("replay_idle", 32'(busy), 0);

        // 5: auto-refresh instance runs back-to-back frames with one IDLE cycle
        fdb_t.delete();
        for (int i = 0; i < 800 && fdb_t.size() < 1; i++) tick();
        bl = busy_low_b;
        rb = n_rise_b;
        for (int i = 0; i < 800 && fdb_t.size() < 2; i++) tick();
        chk_eq("tmo_auto", 32'(fdb_t.size() >= 2), 1);
        if (fdb_t.size() >= 2) begin
            chk_eq("auto_period", 32'(fdb_t[1] - fdb_t[0]), 341);
            chk_eq("auto_idle_cycles", 32'(busy_low_b - bl), 1);
            chk_eq("auto_strobes", 32'(n_rise_b - rb), 34);
        end
        chk_eq("auto_rw", 32'(lcd_rw_b), 0);
        chk_eq("auto_on", 32'(lcd_on_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
